// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request and DataMemory port bundle for load_store_unit
interface load_store_unit_if #(
  parameter int DATA_W = 32
);
  logic              Req;
  logic              Ready;
  logic              Store;
  logic [2:0]        Op;
  logic [DATA_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;
  logic              Done;
  logic              Err;
  logic              DmemRead;
  logic              DmemWrite;
  logic [DATA_W-1:0] DmemAddr;
  logic [DATA_W-1:0] DmemWrData;
  logic [DATA_W-1:0] DmemRdData;

  modport slave (
    input  Req, Store, Op, Addr, WrData, DmemRdData,
    output Ready, RdData, Done, Err, DmemRead, DmemWrite, DmemAddr, DmemWrData
  );

  modport master (
    output Req, Store, Op, Addr, WrData, DmemRdData,
    input  Ready, RdData, Done, Err, DmemRead, DmemWrite, DmemAddr, DmemWrData
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit with read-modify-write sub-word stores
module load_store_unit #(
  parameter int DATA_W = 32
) (
  input  logic Clk,
  input  logic Rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} stateT;

  stateT              state;
  stateT              nextState;
  logic [2:0]         opQ;
  logic [1:0]         laneQ;
  logic [15:0]        wrDataQ;
  logic               errQ;
  logic [DATA_W-1:0]  rdDataQ;
  logic [DATA_W-3:0]  dmemAddrQ;
  logic [DATA_W-1:0]  dmemWrDataQ;

  logic               accept;
  logic               misaligned;
  logic               badOp;
  logic               reqErr;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [DATA_W-1:0]  loadVal;
  logic [DATA_W-1:0]  mergeVal;

  assign accept     = bus.Req && (state == IDLE);
  assign misaligned = ((bus.Op[1:0] == 2'b01) && bus.Addr[0]) ||
                      ((bus.Op[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));
  // Stores ignore Op[2]; loads reject 011, 110 and 111.
  assign badOp      = bus.Store ? (bus.Op[1:0] == 2'b11)
                                : ((bus.Op[1:0] == 2'b11) || (bus.Op == 3'b110));
  assign reqErr     = misaligned || badOp;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    bus.Ready     = 1'b0;
    bus.Done      = 1'b0;
    bus.DmemRead  = 1'b0;
    bus.DmemWrite = 1'b0;
    case (state)
      IDLE: begin
        bus.Ready = 1'b1;
        if (accept) begin
          if (reqErr)                     nextState = RESP;
          else if (!bus.Store)            nextState = LOAD;
          else if (bus.Op[1:0] == 2'b10)  nextState = WRITE;
          else                            nextState = RMW_RD;
        end
      end
      LOAD: begin
        bus.DmemRead = 1'b1;
        nextState    = RESP;
      end
      RMW_RD: begin
        bus.DmemRead = 1'b1;
        nextState    = WRITE;
      end
      WRITE: begin
        bus.DmemWrite = 1'b1;
        nextState     = RESP;
      end
      RESP: begin
        bus.Done  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.Err        = bus.Done && errQ;
  assign bus.RdData     = rdDataQ;
  assign bus.DmemAddr   = {dmemAddrQ, 2'b00};
  assign bus.DmemWrData = dmemWrDataQ;

  always_comb begin
    byteSel = bus.DmemRdData[{laneQ, 3'b000} +: 8];
    halfSel = laneQ[1] ? bus.DmemRdData[31:16] : bus.DmemRdData[15:0];
    case (opQ)
      3'b000:  loadVal = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadVal = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadVal = {24'h0, byteSel};
      3'b101:  loadVal = {16'h0, halfSel};
      default: loadVal = bus.DmemRdData;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the read word is kept.
  always_comb begin
    mergeVal = bus.DmemRdData;
    if (opQ[1:0] == 2'b00) begin
      mergeVal[{laneQ, 3'b000} +: 8] = wrDataQ[7:0];
    end else begin
      mergeVal[{laneQ[1], 4'b0000} +: 16] = wrDataQ;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opQ         <= 3'b000;
      laneQ       <= 2'b00;
      wrDataQ     <= 16'h0;
      errQ        <= 1'b0;
      rdDataQ     <= '0;
      dmemAddrQ   <= '0;
      dmemWrDataQ <= '0;
    end else begin
      if (accept) begin
        opQ     <= bus.Op;
        laneQ   <= bus.Addr[1:0];
        wrDataQ <= bus.WrData[15:0];
        errQ    <= reqErr;
        // Error requests leave the memory port untouched.
        if (!reqErr) begin
          dmemAddrQ <= bus.Addr[DATA_W-1:2];
          if (bus.Store && (bus.Op[1:0] == 2'b10)) begin
            dmemWrDataQ <= bus.WrData;
          end
        end
      end
      if (state == LOAD) begin
        rdDataQ <= loadVal;
      end
      if (state == RMW_RD) begin
        dmemWrDataQ <= mergeVal;
      end
    end
  end

endmodule
